sprite_cmd_scheduler: RTL and testbench

- Sits between the software command port (Avalon write) and the broadcast `writedata` bus feeding all double-buffered sprite display components.
- Queues software sprite commands and releases them only during vertical blanking.
- Stamps every released command with the current back-buffer index (bit 13).
- On a software commit, broadcasts a flip (action 4'hF) to every enabled component so all sprites swap buffers in the same blanking interval (tear-free).

---
 rtl/sprite_cmd_scheduler_pkg.sv | 44 ++++
 rtl/sprite_cmd_scheduler_if.sv | 10 +
 rtl/sprite_cmd_scheduler_cmd_fifo.sv | 54 +++++
 rtl/sprite_cmd_scheduler.sv | 130 +++++++++++++
 tb/tb_sprite_cmd_scheduler.sv | 237 +++++++++++++++++++++++
 5 files changed

// File: rtl/sprite_cmd_scheduler_pkg.sv
// Shared types and constants for the sprite command scheduler: word layout,
// reserved component/action codes and the scheduler FSM encoding.
package sprite_cmd_pkg;

  localparam int COMP_LSB   = 26;
  localparam int CHILD_LSB  = 21;
  localparam int ACTION_LSB = 17;
  localparam int TYPE_LSB   = 14;
  localparam int BUF_BIT    = 13;

  localparam logic [3:0] ACT_FLIP   = 4'hF;
  localparam logic [3:0] ACT_UPDATE = 4'h1;
  localparam logic [5:0] COMP_NOP   = 6'd0;

  typedef struct packed {
    logic [5:0]  component;
    logic [4:0]  child;
    logic [3:0]  action;
    logic [2:0]  action_type;
    logic        buffer;
    logic [12:0] data;
  } sprite_cmd_t;

  typedef enum logic [1:0] {
    ST_ACTIVE = 2'd0,
    ST_DRAIN  = 2'd1,
    ST_FLIP   = 2'd2,
    ST_DONE   = 2'd3
  } sched_state_t;

  function automatic logic [31:0] make_word(input logic [5:0] comp, input logic [4:0] child,
                                            input logic [3:0] action, input logic [2:0] atype,
                                            input logic buf_idx, input logic [12:0] data);
    return (32'(comp) << COMP_LSB) | (32'(child) << CHILD_LSB) |
           (32'(action) << ACTION_LSB) | (32'(atype) << TYPE_LSB) |
           (32'(buf_idx) << BUF_BIT) | 32'(data);
  endfunction

  // Flip broadcast: addressed to one component, carrying the new display buffer.
  function automatic logic [31:0] flip_word(input logic [5:0] id, input logic buf_idx);
    return make_word(id, 5'd0, ACT_FLIP, 3'd0, buf_idx, 13'd0);
  endfunction

endpackage

// File: rtl/sprite_cmd_scheduler_if.sv
// Software command port of the scheduler (Avalon-style write-only port).
// Handshake: cmd_write is a one-cycle strobe carrying cmd_writedata; there is no
// ready/backpressure, so a strobe while the queue is full is dropped and flagged.
interface sprite_cmd_if;
  logic        cmd_write;
  logic [31:0] cmd_writedata;

  modport master (output cmd_write, output cmd_writedata);
  modport slave  (input  cmd_write, input  cmd_writedata);
endinterface

// File: rtl/sprite_cmd_scheduler_cmd_fifo.sv
// Single-clock show-ahead FIFO holding queued sprite command words.
module cmd_fifo #(
  parameter int DEPTH = 16,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          i_push,
  input  logic [31:0]   i_data,
  input  logic          i_pop,
  output logic [31:0]   o_data,
  output logic [AW:0]   o_count,
  output logic          o_full,
  output logic          o_empty
);

  logic [31:0]   r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_push;
  logic          w_pop;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_data  = r_mem[r_rd_ptr];

  // Full/empty use the pre-cycle count, so a push while full is lost even if a
  // pop frees a slot in the same cycle.
  assign w_push = i_push & ~o_full;
  assign w_pop  = i_pop & ~o_empty;

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sprite_cmd_scheduler.sv
// Queues software sprite commands and releases them during vertical blanking,
// stamping the back-buffer index and broadcasting a tear-free flip on COMMIT.
module sprite_cmd_scheduler
  import sprite_cmd_pkg::*;
#(
  parameter int          FIFO_DEPTH = 16,
  parameter int          V_ACTIVE   = 480,
  parameter logic [63:0] FLIP_MASK  = 64'h0000_0000_0000_01FE,
  localparam int         CW         = $clog2(FIFO_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          reset,
  sprite_cmd_if.slave   cmd,
  input  logic [9:0]    vcount,
  output logic [31:0]   writedata,
  output logic          front_buffer,
  output logic [CW-1:0] fifo_count,
  output logic          fifo_full,
  output logic          overflow,
  output logic [15:0]   frame_count,
  output sched_state_t  dbg_state
);

  localparam logic [9:0] VBLANK_LINE = 10'(V_ACTIVE);

  sched_state_t r_state;
  logic [31:0]  r_writedata;
  logic         r_front;
  logic [15:0]  r_frame_count;
  logic [5:0]   r_scan;
  logic         r_vblank_q;
  logic         r_overflow;

  logic         w_vblank;
  logic         w_vblank_rise;
  logic         w_back;
  logic         w_pop;
  logic         w_empty;
  logic         w_full;
  logic [31:0]  w_head_word;
  sprite_cmd_t  w_head;
  sprite_cmd_t  w_stamped;

  cmd_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (cmd.cmd_write),
    .i_data  (cmd.cmd_writedata),
    .i_pop   (w_pop),
    .o_data  (w_head_word),
    .o_count (fifo_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign w_vblank      = (vcount >= VBLANK_LINE);
  assign w_vblank_rise = w_vblank & ~r_vblank_q;
  assign w_back        = ~r_front;
  assign w_head        = sprite_cmd_t'(w_head_word);
  assign w_pop         = (r_state == ST_DRAIN) & w_vblank & ~w_empty;

  always_comb begin
    w_stamped        = w_head;
    w_stamped.buffer = w_back;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state       <= ST_ACTIVE;
      r_writedata   <= '0;
      r_front       <= 1'b0;
      r_frame_count <= '0;
      r_scan        <= '0;
      r_vblank_q    <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_vblank_q  <= w_vblank;
      r_writedata <= '0;
      if (cmd.cmd_write && w_full) r_overflow <= 1'b1;

      case (r_state)
        ST_ACTIVE: begin
          if (w_vblank_rise) r_state <= ST_DRAIN;
        end

        ST_DRAIN: begin
          if (!w_vblank) begin
            r_state <= ST_ACTIVE;
          end else if (w_empty) begin
            r_state <= ST_DONE;
          end else if (w_head.component == COMP_NOP) begin
            // Component 0 is never broadcast: COMMIT starts the flip, anything else is dropped.
            if (w_head.action == ACT_FLIP) begin
              r_state <= ST_FLIP;
              r_scan  <= '0;
            end
          end else begin
            r_writedata <= w_stamped;
          end
        end

        ST_FLIP: begin
          // The sweep ignores vblank so every component flips within 64 clocks.
          if (FLIP_MASK[r_scan]) r_writedata <= flip_word(r_scan, w_back);
          if (r_scan == 6'd63) begin
            r_front       <= w_back;
            r_frame_count <= r_frame_count + 16'd1;
            r_state       <= ST_DONE;
          end else begin
            r_scan <= r_scan + 6'd1;
          end
        end

        ST_DONE: begin
          if (!w_vblank) r_state <= ST_ACTIVE;
        end

        default: r_state <= ST_ACTIVE;
      endcase
    end
  end

  assign writedata    = r_writedata;
  assign front_buffer = r_front;
  assign fifo_full    = w_full;
  assign overflow     = r_overflow;
  assign frame_count  = r_frame_count;
  assign dbg_state    = r_state;

endmodule

// File: tb/tb_sprite_cmd_scheduler.sv
// Bench for sprite_cmd_scheduler: frame-level reference model feeding a
// scoreboard queue, checked by an independent broadcast monitor.
module tb_sprite_cmd_scheduler;
  import sprite_cmd_pkg::*;

  localparam int          DEPTH = 16;
  localparam logic [63:0] MASK  = 64'h0000_0000_0000_01FE;
  localparam logic [31:0] COMMIT_WORD = 32'h001E_0000;

  logic         clk = 1'b0;
  logic         reset;
  logic [9:0]   vcount;
  logic [31:0]  writedata;
  logic         front_buffer;
  logic [4:0]   fifo_count;
  logic         fifo_full;
  logic         overflow;
  logic [15:0]  frame_count;
  sched_state_t dbg_state;

  sprite_cmd_if cmd_bus ();

  sprite_cmd_scheduler #(.FIFO_DEPTH(DEPTH), .V_ACTIVE(480), .FLIP_MASK(MASK)) dut (
    .clk          (clk),
    .reset        (reset),
    .cmd          (cmd_bus.slave),
    .vcount       (vcount),
    .writedata    (writedata),
    .front_buffer (front_buffer),
    .fifo_count   (fifo_count),
    .fifo_full    (fifo_full),
    .overflow     (overflow),
    .frame_count  (frame_count),
    .dbg_state    (dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] model_q[$];
  logic        m_front;
  int          m_frame;
  logic        m_overflow;
  logic        rst_q;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    model_q.delete();
    m_front    = 1'b0;
    m_frame    = 0;
    m_overflow = 1'b0;
  endtask

  // ---------------- scoreboard monitor ----------------
  always @(posedge clk) rst_q <= reset;

  always @(negedge clk) begin
    if (rst_q) begin
      check("reset_nop", writedata, 32'h0);
    end else if (writedata != 32'h0) begin
      if (exp_q.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_word: got %h expected nothing", writedata);
      end else begin
        check("broadcast", writedata, exp_q.pop_front());
      end
    end
  end

  // ---------------- reference model ----------------
  // One vblank of vb_cycles clocks allows vb_cycles-1 pops (the first vblank
  // clock is spent noticing the rising edge).
  task automatic model_frame(input int vb_cycles);
    int          budget;
    logic [31:0] w;
    logic        back;
    budget = vb_cycles - 1;
    while (budget > 0 && model_q.size() > 0) begin
      w = model_q.pop_front();
      budget--;
      back = ~m_front;
      if (w[31:26] == 6'd0) begin
        if (w[20:17] == 4'hF) begin
          for (int n = 0; n < 64; n++)
            if (MASK[n]) exp_q.push_back({6'(n), 5'b0, 4'hF, 3'b0, back, 13'b0});
          m_front = back;
          m_frame = (m_frame + 1) % 65536;
          break;
        end
      end else begin
        w[13] = back;
        exp_q.push_back(w);
      end
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_cmd(input logic [31:0] w);
    cmd_bus.cmd_write     = 1'b1;
    cmd_bus.cmd_writedata = w;
    if (model_q.size() < DEPTH) model_q.push_back(w);
    else m_overflow = 1'b1;
    tick();
    cmd_bus.cmd_write = 1'b0;
  endtask

  task automatic check_state(input string tag);
    check({tag, "_front"}, 32'(front_buffer), 32'(m_front));
    check({tag, "_frames"}, 32'(frame_count), 32'(m_frame));
    check({tag, "_count"}, 32'(fifo_count), 32'(model_q.size()));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_overflow));
  endtask

  task automatic run_frame(input int vb_cycles, input string tag);
    model_frame(vb_cycles);
    vcount = 10'd479;
    tick();
    for (int i = 0; i < vb_cycles; i++) begin
      vcount = 10'(480 + i);
      tick();
    end
    vcount = 10'd0;
    repeat (80) tick();
    check({tag, "_pending"}, 32'(exp_q.size()), 32'd0);
    check_state(tag);
  endtask

  function automatic logic [31:0] rand_cmd();
    logic [31:0] w;
    int          r;
    r = $urandom_range(0, 9);
    w = $urandom;
    if (r == 0) begin
      w = (w & 32'h03FF_FFFF) | COMMIT_WORD;
    end else if (r == 1) begin
      w = w & 32'h03FF_FFFF;
      if (w[20:17] == 4'hF) w[17] = 1'b0;
    end else begin
      if (w[31:26] == 6'd0) w[26] = 1'b1;
      if (r == 2) w[20:17] = ACT_UPDATE;
    end
    return w;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    reset                 = 1'b1;
    vcount                = 10'd0;
    cmd_bus.cmd_write     = 1'b0;
    cmd_bus.cmd_writedata = 32'h0;
    model_reset();
    repeat (3) tick();
    check("rst_writedata", writedata, 32'h0);
    check("rst_full", 32'(fifo_full), 32'd0);
    check_state("rst");
    reset  = 1'b0;
    vcount = 10'd100;
    repeat (100) tick();
    check("idle_writedata", writedata, 32'h0);
    check_state("idle");

    // Two commit frames: stamping alternates and the buffer flips back
    push_cmd(32'h2002_3005);
    push_cmd(COMMIT_WORD);
    run_frame(45, "frame1");
    push_cmd(32'h2002_3005);
    push_cmd(COMMIT_WORD);
    run_frame(45, "frame2");

    // Overflow: 17 writes into 16 entries
    vcount = 10'd200;
    for (int i = 0; i < 17; i++) push_cmd({6'(1 + (i % 63)), 26'($urandom)});
    check("ovf_full", 32'(fifo_full), 32'd1);
    check("ovf_count", 32'(fifo_count), 32'd16);
    check("ovf_flag", 32'(overflow), 32'd1);
    run_frame(45, "ovf_drain");

    // Short vblank: drain stops early, leftovers stay queued, no flip
    for (int i = 0; i < 16; i++) push_cmd({6'(1 + $urandom_range(0, 62)), 26'($urandom)});
    run_frame(8, "partial");
    run_frame(45, "partial_rest");

    // Randomized frames
    for (int f = 0; f < 8; f++) begin
      int n;
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) push_cmd(rand_cmd());
      run_frame($urandom_range(4, 50), "rand");
    end

    // Reset in the middle of the flip sweep (scan index 20)
    reset = 1'b1;
    repeat (2) tick();
    reset = 1'b0;
    model_reset();
    push_cmd(COMMIT_WORD);
    void'(model_q.pop_front());
    for (int n = 0; n < 20; n++)
      if (MASK[n]) exp_q.push_back({6'(n), 5'b0, 4'hF, 3'b0, 1'b1, 13'b0});
    vcount = 10'd479;
    tick();
    vcount = 10'd480;
    tick();
    tick();
    repeat (20) tick();
    reset  = 1'b1;
    vcount = 10'd0;
    tick();
    check("midflip_writedata", writedata, 32'h0);
    check("midflip_front", 32'(front_buffer), 32'd0);
    check("midflip_count", 32'(fifo_count), 32'd0);
    reset = 1'b0;
    repeat (100) tick();
    check("midflip_pending", 32'(exp_q.size()), 32'd0);
    check_state("midflip");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
